note_key_debouncer: RTL and testbench
=====================================

// Module: note_key_debouncer
// PURPOSE
//  Front end of the keyboard. Samples 13 raw note keys (C4..C5) and synchronises
//  each one into the 50 MHz domain. Debounces every key on a 1 kHz sample tick.
//  Drives the level enables en_C..en_C5 that feed the tone generators and the LCD
//  note display. Also reports the highest sounding note plus a new-press strobe.
// PARAMETERS
//  N_KEYS          13     number of note keys; bit 0 = C4 ... bit 12 = C5
//  CLK_DIV         50000  CLK_50MHz cycles per sample tick (1 kHz)
//  STABLE_TICKS    20     consecutive differing ticks needed to accept a change (>=1)
//  KEY_ACTIVE_LOW  1      1: key_raw bit is 0 when pressed; 0: 1 when pressed
// PORTS
//  CLK_50MHz    in   1       system clock
//  resetn       in   1       asynchronous reset, active-low
//  key_raw      in   N_KEYS  raw key inputs, asynchronous, bouncing
//  en_notes     out  N_KEYS  debounced pressed state, active-high; bit order = parameter above
//  note_valid   out  1       1 while any en_notes bit is set
//  note_idx     out  4       index of highest set en_notes bit; 0 when note_valid=0
//  press_pulse  out  1       1-cycle strobe when any en_notes bit rises
// BEHAVIOUR
//  Clock and reset
//  - One clock, CLK_50MHz. resetn is asynchronous, active-low.
//  - Reset clears all outputs, debounce counters and the prescaler to 0.
//  - Reset loads the synchroniser flops with the "released" level.
//  - A key held through reset is reported as a fresh press after debounce.
//  Input conditioning
//  - Each key passes through a 2-flop synchroniser.
//  - The synchronised value is polarity-corrected: pressed = 1.
//  Prescaler
//  - Counts 0..CLK_DIV-1 and wraps.
//  - tick = 1 for exactly one cycle, when the count is CLK_DIV-1.
//  Per-key debounce (acts only on a tick; holds otherwise)
//  - sample == state: counter <= 0.
//  - sample != state and counter == STABLE_TICKS-1: state <= sample, counter <= 0.
//  - otherwise: counter <= counter+1.
//  - Counter width = clog2(STABLE_TICKS)+1. It never exceeds STABLE_TICKS-1.
//  - Any agreeing sample restarts qualification, so bounce shorter than
//    STABLE_TICKS ticks never toggles the state.
//  - en_notes is the state register itself (registered, no combinational path).
//  Latency from a clean edge on key_raw to en_notes
//  - Minimum: 2 + (STABLE_TICKS-1)*CLK_DIV + 1 cycles.
//  - Maximum: 2 + STABLE_TICKS*CLK_DIV + 1 cycles (depends on tick phase).
//  Derived outputs (registered, one cycle after the en_notes update)
//  - note_valid = |en_notes.
//  - note_idx = highest set bit, so C5 has priority over C4.
//  - press_pulse = |(en_notes & ~en_notes_q), where en_notes_q is en_notes delayed one cycle.
//  Boundary conditions
//  - Several keys accepted on the same tick update together.
//  - Simultaneous presses give a single press_pulse.
//  - A press and a release on the same tick give press_pulse=1.
//  - A release only updates note_idx and note_valid; no pulse.
//  - Releasing the top note drops note_idx to the next-highest held key.
//  - Releasing all keys gives note_idx=0 and note_valid=0.
//  - resetn asserted mid-qualification discards partial counts immediately.
// STRUCTURE
//  - Shared package keyboard_pkg:
//    - N_KEYS = 13.
//    - Note index constants NOTE_C=0, NOTE_CS=1, ... NOTE_B=11, NOTE_C5=12,
//      also used by the tone generators and the LCD display block.
//  - One sub-module, key_debounce_cell (instantiated N_KEYS times):
//    - Contains the 2-flop synchroniser, polarity fix, counter and state flop.
//    - Inputs: clock, reset, tick. Output: one en_notes bit.
//  - Prescaler, priority encoder and press-edge detect live in the top module.
// TESTING (bench overrides CLK_DIV=4, STABLE_TICKS=3, KEY_ACTIVE_LOW=1)
//  1. Reset: hold resetn=0, key_raw=13'h0000 (all pressed).
//     -> all outputs 0. After release, en_notes=13'h1FFF within 2+3*4+1=15 cycles,
//        note_idx=12, one press_pulse.
//  2. Clean press: key_raw[0] 1->0 and held.
//     -> en_notes[0] rises between cycle 11 and cycle 15; note_idx=0, note_valid=1,
//        press_pulse high for exactly 1 cycle.
//  3. Bounce: toggle key_raw[5] every 6 cycles (less than 3 ticks) for 60 cycles, then hold 0.
//     -> en_notes[5] stays 0 during the bounce; rises only after 3 stable ticks.
//  4. Simultaneous press: key_raw[4] and key_raw[9] fall in the same cycle.
//     -> both bits rise in the same cycle; note_idx=9; a single 1-cycle press_pulse.
//  5. Release top note: from case 4, release key 9.
//     -> after debounce en_notes=13'h0010, note_idx=4, press_pulse stays 0.
//     Then release key 4 -> note_valid=0, note_idx=0.
//  6. Reset mid-operation: key_raw[7] pressed, pulse resetn low for 1 cycle
//     after 2 ticks (before acceptance).
//     -> all outputs 0 immediately; en_notes[7] rises a full debounce period
//        after resetn is released.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared keyboard definitions: key count, note index width and note numbering.
// The note constants are also used by the tone generators and the LCD display.
package keyboard_pkg;

    localparam int N_KEYS = 13;
    localparam int NOTE_W = 4;

    localparam int NOTE_C  = 0;
    localparam int NOTE_CS = 1;
    localparam int NOTE_D  = 2;
    localparam int NOTE_DS = 3;
    localparam int NOTE_E  = 4;
    localparam int NOTE_F  = 5;
    localparam int NOTE_FS = 6;
    localparam int NOTE_G  = 7;
    localparam int NOTE_GS = 8;
    localparam int NOTE_A  = 9;
    localparam int NOTE_AS = 10;
    localparam int NOTE_B  = 11;
    localparam int NOTE_C5 = 12;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, polarity fix, tick-driven debounce counter and
// the accepted state flop, which is driven straight out as the note enable.
module key_debounce_cell #(
    parameter int STABLE_TICKS   = 20,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic CLK_50MHz,
    input  logic resetn,
    input  logic tick,
    input  logic key_raw,
    output logic en_note
);

    localparam int              CNT_W    = $clog2(STABLE_TICKS) + 1;
    localparam logic            RELEASED = 1'(KEY_ACTIVE_LOW);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(STABLE_TICKS - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             sample;
    logic [CNT_W-1:0] stable_cnt;

    // Synchroniser; reset loads the released level so a held key looks like a fresh press.
    always_ff @(posedge CLK_50MHz or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= RELEASED;
            sync_q2 <= RELEASED;
        end else begin
            sync_q1 <= key_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Pressed reads as 1 regardless of the key's electrical polarity.
    assign sample = sync_q2 ^ RELEASED;

    // Debounce: a change is accepted only after STABLE_TICKS consecutive disagreeing ticks.
    always_ff @(posedge CLK_50MHz or negedge resetn) begin
        if (!resetn) begin
            stable_cnt <= '0;
            en_note    <= 1'b0;
        end else if (tick) begin
            if (sample == en_note) begin
                stable_cnt <= '0;
            end else if (stable_cnt == LAST) begin
                en_note    <= sample;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_key_debouncer.sv
// Keyboard front end: prescaler for the debounce tick, one debounce cell per key,
// highest-note priority encoder and the new-press strobe.
// Output semantics: note_valid is a level that qualifies note_idx (no ready side;
// the consumer samples note_idx whenever note_valid=1). press_pulse is a 1-cycle strobe.
module note_key_debouncer
    import keyboard_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int STABLE_TICKS   = 20,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic              CLK_50MHz,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] en_notes,
    output logic              note_valid,
    output logic [NOTE_W-1:0] note_idx,
    output logic              press_pulse
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]  presc_cnt;
    logic              tick;
    logic [N_KEYS-1:0] en_notes_q;
    logic [NOTE_W-1:0] top_idx;

    // Prescaler wraps at CLK_DIV-1; tick is high for that single count.
    always_ff @(posedge CLK_50MHz or negedge resetn) begin
        if (!resetn) begin
            presc_cnt <= '0;
        end else if (presc_cnt == DIV_LAST) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    assign tick = (presc_cnt == DIV_LAST);

    genvar k;
    generate
        for (k = 0; k < N_KEYS; k++) begin : g_key
            key_debounce_cell #(
                .STABLE_TICKS  (STABLE_TICKS),
                .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
            ) u_cell (
                .CLK_50MHz(CLK_50MHz),
                .resetn   (resetn),
                .tick     (tick),
                .key_raw  (key_raw[k]),
                .en_note  (en_notes[k])
            );
        end
    endgenerate

    // Priority encoder: later (higher) keys overwrite, so C5 wins over C4.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (en_notes[i]) begin
                top_idx = NOTE_W'(i);
            end
        end
    end

    // Derived outputs, registered one cycle behind en_notes; only rising bits strobe.
    always_ff @(posedge CLK_50MHz or negedge resetn) begin
        if (!resetn) begin
            en_notes_q  <= '0;
            note_valid  <= 1'b0;
            note_idx    <= '0;
            press_pulse <= 1'b0;
        end else begin
            en_notes_q  <= en_notes;
            note_valid  <= |en_notes;
            note_idx    <= top_idx;
            press_pulse <= |(en_notes & ~en_notes_q);
        end
    end

endmodule

// File: tb/tb_note_key_debouncer.sv
// Bench for note_key_debouncer with a fast tick (CLK_DIV=4, STABLE_TICKS=3).
// A tick-level reference model predicts every en_notes change into exp_q; a
// monitor pops and compares whenever the DUT's en_notes changes.
module tb_note_key_debouncer;

    localparam int N     = 13;
    localparam int D     = 4;
    localparam int S     = 3;
    localparam int EXP_W = N + 1 + 4 + 1 + 1;  // {from_reset, en, valid, idx, press}

    // ---------------- clock / reset ----------------
    logic          CLK_50MHz = 1'b0;
    logic          resetn    = 1'b0;
    logic [N-1:0]  key_raw   = '0;
    logic [N-1:0]  en_notes;
    logic          note_valid;
    logic [3:0]    note_idx;
    logic          press_pulse;

    always #5 CLK_50MHz = ~CLK_50MHz;

    note_key_debouncer #(
        .CLK_DIV       (D),
        .STABLE_TICKS  (S),
        .KEY_ACTIVE_LOW(1)
    ) dut (
        .CLK_50MHz  (CLK_50MHz),
        .resetn     (resetn),
        .key_raw    (key_raw),
        .en_notes   (en_notes),
        .note_valid (note_valid),
        .note_idx   (note_idx),
        .press_pulse(press_pulse)
    );

    int checks   = 0;
    int failures = 0;

    logic [EXP_W-1:0] exp_q[$];
    time              exp_t_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] highest(input logic [N-1:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < N; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    // ---------------- reference model ----------------
    // Raw history (two-cycle delay), tick every D-th cycle since reset, and per-key
    // count of consecutive ticks whose sample disagrees with the accepted state.
    logic [N-1:0] m_s1    = '1;
    logic [N-1:0] m_s2    = '1;
    logic [N-1:0] m_state = '0;
    int           m_run[N];
    int           m_n     = 0;

    task automatic push_exp(input logic [N-1:0] nv, input logic [N-1:0] ov, input logic rst);
        exp_q.push_back({rst, nv, |nv, highest(nv), rst ? 1'b0 : |(nv & ~ov)});
        exp_t_q.push_back($time);
    endtask

    initial begin
        logic [N-1:0] nxt;
        logic         pressed;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        forever begin
            @(posedge CLK_50MHz or negedge resetn);
            if (!resetn) begin
                if (m_state != '0) push_exp('0, m_state, 1'b1);
                m_s1 = '1;
                m_s2 = '1;
                m_state = '0;
                for (int i = 0; i < N; i++) m_run[i] = 0;
                m_n = 0;
            end else begin
                nxt = m_state;
                if ((m_n % D) == D - 1) begin
                    for (int i = 0; i < N; i++) begin
                        pressed = ~m_s2[i];
                        if (pressed != m_state[i]) begin
                            m_run[i] = m_run[i] + 1;
                            if (m_run[i] == S) begin
                                nxt[i] = pressed;
                                m_run[i] = 0;
                            end
                        end else begin
                            m_run[i] = 0;
                        end
                    end
                end
                m_s2 = m_s1;
                m_s1 = key_raw;
                m_n  = m_n + 1;
                if (nxt != m_state) push_exp(nxt, m_state, 1'b0);
                m_state = nxt;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [N-1:0]     last_en;
        logic             pending;
        logic [EXP_W-1:0] cur;
        time              ct;
        last_en = '0;
        pending = 1'b0;
        cur     = '0;
        forever begin
            @(negedge CLK_50MHz);
            if (pending) begin
                chk("sb_note_valid", 32'(note_valid), 32'(cur[5]));
                chk("sb_note_idx", 32'(note_idx), 32'(cur[4:1]));
                chk("sb_press_pulse", 32'(press_pulse), 32'(cur[0]));
                pending = 1'b0;
            end else begin
                chk("sb_no_stray_press", 32'(press_pulse), 32'd0);
            end
            if (en_notes !== last_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_change actual=%0h required=%0h", en_notes, last_en);
                end else begin
                    cur = exp_q.pop_front();
                    ct  = exp_t_q.pop_front();
                    chk("sb_en_notes", 32'(en_notes), 32'(cur[EXP_W-2:6]));
                    if (!cur[EXP_W-1]) chk("sb_update_time", 32'($time - ct), 32'd5);
                    pending = 1'b1;
                end
                last_en = en_notes;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge CLK_50MHz);
        #1;
    endtask

    // Wait for (en_notes & mask) == val; latency counted in clock edges after the call.
    task automatic wait_bits(input string name, input logic [N-1:0] mask,
                             input logic [N-1:0] val, input int lo, input int hi);
        int   lat;
        logic found;
        lat   = 0;
        found = 1'b0;
        while (!found && lat < hi + 5) begin
            @(posedge CLK_50MHz);
            lat++;
            @(negedge CLK_50MHz);
            if ((en_notes & mask) == val) found = 1'b1;
        end
        checks++;
        if (!found || lat < lo || lat > hi) begin
            failures++;
            $display("FAIL %s latency=%0d required=%0d..%0d found=%0d", name, lat, lo, hi, found);
        end
        step(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic seen;
        int   k;
        int   k2;

        // 1: reset with every key pressed.
        resetn  = 1'b0;
        key_raw = '0;
        step(3);
        chk("rst_en_notes", 32'(en_notes), 32'd0);
        chk("rst_note_valid", 32'(note_valid), 32'd0);
        chk("rst_note_idx", 32'(note_idx), 32'd0);
        chk("rst_press_pulse", 32'(press_pulse), 32'd0);
        resetn = 1'b1;
        wait_bits("t1_all_pressed", '1, '1, 11, 15);
        chk("t1_note_idx", 32'(note_idx), 32'd12);
        chk("t1_note_valid", 32'(note_valid), 32'd1);
        chk("t1_press", 32'(press_pulse), 32'd1);
        step(1);
        chk("t1_press_drop", 32'(press_pulse), 32'd0);

        key_raw = '1;
        wait_bits("t1_all_released", '1, '0, 11, 15);
        chk("t1_rel_valid", 32'(note_valid), 32'd0);
        step(3);

        // 2: clean press of C4.
        key_raw[0] = 1'b0;
        wait_bits("t2_press_c4", 13'h0001, 13'h0001, 11, 15);
        chk("t2_note_idx", 32'(note_idx), 32'd0);
        chk("t2_note_valid", 32'(note_valid), 32'd1);
        chk("t2_press", 32'(press_pulse), 32'd1);
        step(1);
        chk("t2_press_drop", 32'(press_pulse), 32'd0);
        key_raw[0] = 1'b1;
        wait_bits("t2_release_c4", 13'h0001, 13'h0000, 11, 15);
        step(2);

        // 3: bounce on key 5 shorter than three ticks, then hold pressed.
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c % 6 == 0) key_raw[5] = ~key_raw[5];
            @(negedge CLK_50MHz);
            if (en_notes[5]) seen = 1'b1;
            step(1);
        end
        chk("t3_bounce_ignored", 32'(seen), 32'd0);
        key_raw[5] = 1'b0;
        wait_bits("t3_settle_press", 13'h0020, 13'h0020, 11, 15);
        key_raw[5] = 1'b1;
        wait_bits("t3_release", 13'h0020, 13'h0000, 11, 15);
        step(2);

        // 4: simultaneous press of keys 4 and 9.
        key_raw[4] = 1'b0;
        key_raw[9] = 1'b0;
        wait_bits("t4_any_rise", 13'h0210, 13'h0210, 11, 15);
        chk("t4_note_idx", 32'(note_idx), 32'd9);
        chk("t4_press", 32'(press_pulse), 32'd1);
        step(1);
        chk("t4_press_drop", 32'(press_pulse), 32'd0);
        step(2);

        // 5: release top note, then the remaining one.
        key_raw[9] = 1'b1;
        wait_bits("t5_release_top", '1, 13'h0010, 11, 15);
        chk("t5_note_idx", 32'(note_idx), 32'd4);
        chk("t5_note_valid", 32'(note_valid), 32'd1);
        chk("t5_no_press", 32'(press_pulse), 32'd0);
        key_raw[4] = 1'b1;
        wait_bits("t5_release_all", '1, '0, 11, 15);
        chk("t5_valid_zero", 32'(note_valid), 32'd0);
        chk("t5_idx_zero", 32'(note_idx), 32'd0);
        step(2);

        // 6: reset during qualification of key 7.
        key_raw[7] = 1'b0;
        step(8);
        resetn = 1'b0;
        #1;
        chk("t6_rst_en", 32'(en_notes), 32'd0);
        chk("t6_rst_valid", 32'(note_valid), 32'd0);
        chk("t6_rst_idx", 32'(note_idx), 32'd0);
        chk("t6_rst_press", 32'(press_pulse), 32'd0);
        step(1);
        resetn = 1'b1;
        wait_bits("t6_full_period", 13'h0080, 13'h0080, 11, 15);
        chk("t6_note_idx", 32'(note_idx), 32'd7);
        key_raw[7] = 1'b1;
        step(20);

        // Random presses, releases, chords and bounce bursts; the scoreboard checks all.
        for (int it = 0; it < 40; it++) begin
            k  = $urandom_range(0, N - 1);
            k2 = $urandom_range(0, N - 1);
            case ($urandom_range(0, 2))
                0: key_raw[k] = ~key_raw[k];
                1: begin
                    key_raw[k]  = ~key_raw[k];
                    key_raw[k2] = ~key_raw[k2];
                end
                default: begin
                    repeat ($urandom_range(1, 4)) begin
                        key_raw[k] = ~key_raw[k];
                        step($urandom_range(1, 10));
                    end
                end
            endcase
            step($urandom_range(2, 30));
        end

        key_raw = '1;
        step(40);
        chk("end_all_released", 32'(en_notes), 32'd0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
